// File: rtl/sw_job_sequencer_pkg.sv
// Shared types and result layout for the Smith-Waterman job sequencer.
// The result word packs row, column and score into the low 32 bits of the TX frame.
package sw_pkg;

   typedef enum logic [2:0] {
      S_LOAD_REF,
      S_LOAD_READ,
      S_ISSUE,
      S_WAIT,
      S_SEND
   } state_t;

   localparam int SCORE_W   = 10;
   localparam int POS_W     = 7;
   localparam int ROW_LSB   = 24;
   localparam int COL_LSB   = 16;
   localparam int SCORE_LSB = 0;

   localparam logic [31:0] TIMEOUT_RESULT = 32'hFFFF_FFFF;

   function automatic logic [31:0] pack_result(input logic [POS_W-1:0]   row,
                                               input logic [POS_W-1:0]   col,
                                               input logic [SCORE_W-1:0] score);
      logic [31:0] v;
      v                  = '0;
      v[ROW_LSB +: 8]    = {1'b0, row};
      v[COL_LSB +: 8]    = {1'b0, col};
      v[SCORE_LSB +: 16] = {6'b0, score};
      return v;
   endfunction

endpackage

// File: rtl/sw_job_sequencer_byte_shifter.sv
// N-byte MSB-first shift register with parallel load and a byte counter.
// o_done flags the shift that completes N bytes; the counter then restarts at 0.
module sw_byte_shifter #(
   parameter  int N_BYTES = 32,
   localparam int W       = N_BYTES * 8,
   localparam int CNT_W   = $clog2(N_BYTES)
) (
   input  logic             avm_clk,
   input  logic             avm_rst,
   input  logic             i_load,
   input  logic [W-1:0]     i_load_data,
   input  logic             i_shift,
   input  logic [7:0]       i_byte,
   output logic [W-1:0]     o_data,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_done
);

   logic [W-1:0]     r_data;
   logic [CNT_W-1:0] r_cnt;

   assign o_data = r_data;
   assign o_cnt  = r_cnt;
   assign o_done = i_shift && (r_cnt == CNT_W'(N_BYTES - 1));

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         r_data <= '0;
         r_cnt  <= '0;
      end else if (i_load) begin
         r_data <= i_load_data;
         r_cnt  <= '0;
      end else if (i_shift) begin
         r_data <= {r_data[W-9:0], i_byte};
         r_cnt  <= o_done ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sw_job_sequencer.sv
// Collects a 64-byte job, hands it to the SW core, waits for the result under a
// watchdog and streams a 31-byte result frame back out MSB first.
module sw_job_sequencer
   import sw_pkg::*;
#(
   parameter int REF_BYTES      = 32,
   parameter int READ_BYTES     = 32,
   parameter int OUT_BYTES      = 31,
   parameter int SEQ_LEN        = 128,
   parameter int TIMEOUT_W      = 20,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    avm_clk,
   input  logic                    avm_rst,
   input  logic [7:0]              in_byte,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    core_o_ready,
   output logic                    core_i_valid,
   output logic [REF_BYTES*8-1:0]  core_seq_ref,
   output logic [READ_BYTES*8-1:0] core_seq_read,
   output logic [7:0]              core_ref_len,
   output logic [7:0]              core_read_len,
   input  logic                    core_o_valid,
   output logic                    core_i_ready,
   input  logic [SCORE_W-1:0]      core_score,
   input  logic [POS_W-1:0]        core_col,
   input  logic [POS_W-1:0]        core_row,
   output logic [7:0]              out_byte,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy,
   output logic                    timeout_err,
   output logic [15:0]             job_count
);

   localparam int OUT_W = OUT_BYTES * 8;

   state_t                         r_state;
   state_t                         w_next;
   logic   [TIMEOUT_W-1:0]         r_wdog;
   logic                           r_timeout_err;
   logic   [15:0]                  r_job_count;

   logic                           w_in_xfer, w_ref_shift, w_read_shift;
   logic                           w_ref_done, w_read_done, w_res_done;
   logic                           w_expire, w_res_load, w_out_xfer;
   logic   [OUT_W-1:0]             w_res_data, w_res;
   logic   [$clog2(REF_BYTES)-1:0] w_ref_cnt;
   logic   [$clog2(READ_BYTES)-1:0] w_read_cnt;
   logic   [$clog2(OUT_BYTES)-1:0] w_res_cnt;
   logic                           w_cnt_unused;

   // All handshake outputs decode from state alone, so no input reaches an output combinationally.
   assign in_ready      = (r_state == S_LOAD_REF) || (r_state == S_LOAD_READ);
   assign core_i_valid  = (r_state == S_ISSUE);
   assign core_i_ready  = (r_state == S_WAIT);
   assign out_valid     = (r_state == S_SEND);
   assign out_byte      = w_res[OUT_W-1 -: 8];
   assign core_ref_len  = 8'(SEQ_LEN);
   assign core_read_len = 8'(SEQ_LEN);
   assign busy          = (r_state != S_LOAD_REF) || (w_ref_cnt != '0);
   assign timeout_err   = r_timeout_err;
   assign job_count     = r_job_count;
   assign w_cnt_unused  = ^{w_read_cnt, w_res_cnt};

   assign w_in_xfer    = in_valid && in_ready;
   assign w_ref_shift  = w_in_xfer && (r_state == S_LOAD_REF);
   assign w_read_shift = w_in_xfer && (r_state == S_LOAD_READ);
   assign w_out_xfer   = out_valid && out_ready;
   assign w_expire     = (r_wdog == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   // A real result always takes priority over an expiring watchdog.
   assign w_res_load   = core_i_ready && (core_o_valid || w_expire);
   assign w_res_data   = {{(OUT_W-32){1'b0}},
                          core_o_valid ? pack_result(core_row, core_col, core_score) : TIMEOUT_RESULT};

   sw_byte_shifter #(.N_BYTES(REF_BYTES)) u_ref (
      .avm_clk(avm_clk), .avm_rst(avm_rst),
      .i_load(1'b0), .i_load_data('0),
      .i_shift(w_ref_shift), .i_byte(in_byte),
      .o_data(core_seq_ref), .o_cnt(w_ref_cnt), .o_done(w_ref_done)
   );

   sw_byte_shifter #(.N_BYTES(READ_BYTES)) u_read (
      .avm_clk(avm_clk), .avm_rst(avm_rst),
      .i_load(1'b0), .i_load_data('0),
      .i_shift(w_read_shift), .i_byte(in_byte),
      .o_data(core_seq_read), .o_cnt(w_read_cnt), .o_done(w_read_done)
   );

   sw_byte_shifter #(.N_BYTES(OUT_BYTES)) u_res (
      .avm_clk(avm_clk), .avm_rst(avm_rst),
      .i_load(w_res_load), .i_load_data(w_res_data),
      .i_shift(w_out_xfer), .i_byte(8'h00),
      .o_data(w_res), .o_cnt(w_res_cnt), .o_done(w_res_done)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_LOAD_REF:  if (w_ref_done)   w_next = S_LOAD_READ;
         S_LOAD_READ: if (w_read_done)  w_next = S_ISSUE;
         S_ISSUE:     if (core_o_ready) w_next = S_WAIT;
         S_WAIT:      if (w_res_load)   w_next = S_SEND;
         S_SEND:      if (w_res_done)   w_next = S_LOAD_REF;
         default:                       w_next = S_LOAD_REF;
      endcase
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         r_state       <= S_LOAD_REF;
         r_wdog        <= '0;
         r_timeout_err <= 1'b0;
         r_job_count   <= '0;
      end else begin
         r_state <= w_next;
         // Watchdog only runs in S_WAIT and is held at zero everywhere else.
         r_wdog  <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;
         if (w_read_done)
            r_timeout_err <= 1'b0;
         else if (w_res_load && !core_o_valid)
            r_timeout_err <= 1'b1;
         if (core_i_ready && core_o_valid)
            r_job_count <= r_job_count + 16'd1;
      end
   end

endmodule

// File: doc/sw_job_sequencer.md
Name: sw_job_sequencer

Overview:
- Sequences one Smith-Waterman job at a time through the existing SW core.
- Collects a 64-byte job from the byte-wide RX side:
  - first 32 bytes: reference, 128 bases × 2 bit;
  - next 32 bytes: read, 128 bases × 2 bit.
- Issues the job to the core over a valid/ready handshake, then waits for the result.
- Packs score/row/column into a 31-byte result stream for the TX side; enforces a watchdog timeout.
- Sits between the Avalon-MM UART wrapper FSM and the SW core, replacing ad-hoc core tie-offs.

Parameters:
REF_BYTES, 32, bytes forming the reference vector (MSB-first)
READ_BYTES, 32, bytes forming the read vector (MSB-first)
OUT_BYTES, 31, result bytes emitted per job
SEQ_LEN, 128, value driven on both length outputs
TIMEOUT_W, 20, watchdog counter width
TIMEOUT_CYCLES, 1000000, cycles in S_WAIT before abort

Ports:
avm_clk  in  1  clock
avm_rst  in  1  reset, asynchronous, active-high
in_byte  in  8  RX byte
in_valid  in  1  RX byte present
in_ready  out  1  sequencer accepts byte
core_o_ready  in  1  core can take a job
core_i_valid  out  1  job valid to core
core_seq_ref  out  256  reference vector
core_seq_read  out  256  read vector
core_ref_len  out  8  = SEQ_LEN
core_read_len  out  8  = SEQ_LEN
core_o_valid  in  1  core result valid
core_i_ready  out  1  sequencer takes result
core_score  in  10  alignment score (unsigned)
core_col  in  7  best column
core_row  in  7  best row
out_byte  out  8  TX byte
out_valid  out  1  TX byte present
out_ready  in  1  TX consumer accepts
busy  out  1  state != S_LOAD_REF or byte counter != 0
timeout_err  out  1  last job aborted by watchdog
job_count  out  16  completed jobs, wraps 0xFFFF→0

Behaviour:
- Reset (async):
  - state = S_LOAD_REF; all counters 0.
  - core_seq_ref/core_seq_read/result register = 0.
  - core_i_valid = 0, core_i_ready = 0, out_valid = 0, out_byte = 0.
  - timeout_err = 0, job_count = 0, in_ready = 1.
  - Reset mid-job discards everything; no partial result is emitted.
- Byte transfer happens iff valid && ready in the same cycle. All control outputs are registered or decoded from state only, with no combinational in→out paths.
- States:
  - S_LOAD_REF:
    - in_ready = 1; each transfer does ref <= {ref[247:0], in_byte}.
    - The REF_BYTES-th transfer → S_LOAD_READ with counter cleared.
  - S_LOAD_READ:
    - Same shift into read.
    - The READ_BYTES-th transfer → S_ISSUE; clears timeout_err.
  - S_ISSUE:
    - in_ready = 0, core_i_valid = 1.
    - core_o_ready = 1 → S_WAIT with the watchdog cleared.
    - core_i_valid rises the cycle after the last input byte.
  - S_WAIT:
    - core_i_ready = 1; the watchdog increments each cycle.
    - core_o_valid → load R and go to S_SEND:
      - R[247:32] = 0;
      - R[31:24] = {1'b0,row}; R[23:16] = {1'b0,col};
      - R[15:0] = {6'b0,score};
      - job_count++.
    - Else if watchdog == TIMEOUT_CYCLES-1 → R[31:0] = 32'hFFFF_FFFF, timeout_err = 1, → S_SEND; job_count is not incremented.
    - Both in the same cycle → the valid result wins and timeout_err stays 0.
  - S_SEND:
    - out_valid = 1, out_byte = R[247:240].
    - Each transfer does R <= R << 8.
    - After OUT_BYTES transfers → S_LOAD_REF. out_valid drops the next cycle.
- Sequence vectors stay stable from S_ISSUE until the next S_LOAD_REF byte; the core may sample them at any time in S_WAIT.
- in_valid outside the load states is ignored (in_ready = 0); no byte is lost or duplicated.
- out_ready held low stalls S_SEND indefinitely; the watchdog is inactive outside S_WAIT.
- core_o_valid outside S_WAIT is ignored (core_i_ready = 0).

Decomposition:
- Package sw_pkg:
  - state enum;
  - SCORE_W = 10, POS_W = 7;
  - result field offsets;
  - TIMEOUT_RESULT = 32'hFFFF_FFFF.
- One sub-module: sw_byte_shifter. It is a parameterised N-byte shift register with load/shift/count-done and is instanced for ref, read, and result.
- The FSM and watchdog stay in the top level.

Test Plan:
- Reset mid-load:
  - Stimulus: send 20 bytes, pulse avm_rst, then send a full 64-byte job.
  - Required: only one core_i_valid, with ref equal to the post-reset bytes.
- Nominal job:
  - Stimulus: ref bytes 0x00..0x1F, read bytes 0x20..0x3F; core returns score = 0x17F, col = 5, row = 9 after 300 cycles.
  - Required: core_i_valid the cycle after byte 64; core_seq_ref[255:248] = 0x00 and core_seq_read[7:0] = 0x3F.
  - Required: 31 bytes out — 27×0x00, then 0x09, 0x05, 0x01, 0x7F; job_count = 1.
- Core backpressure:
  - Stimulus: hold core_o_ready = 0 for 50 cycles after load.
  - Required: core_i_valid stays 1 and vectors stay stable; handoff occurs on the first core_o_ready.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 100, core never asserts core_o_valid.
  - Required: after 100 cycles in S_WAIT, timeout_err = 1 and last 4 out bytes = 0xFF; job_count unchanged.
  - Required: the next job's load completion clears timeout_err.
- Simultaneous result and timeout:
  - Stimulus: core_o_valid in the cycle the watchdog expires.
  - Required: real result emitted, timeout_err = 0.
- TX stall and back-to-back jobs:
  - Stimulus: out_ready toggles 1/0 per cycle; second job bytes offered during S_SEND.
  - Required: every result byte appears exactly once in order.
  - Required: in_ready = 0 until the 31st transfer; second job completes correctly.
